// File: rtl/column_scorer_pkg.sv
// Shared game constants, state encoding and coordinate helpers for the column scorer.
// Geometry is evaluated in signed 12-bit so that subtractions near the screen origin stay ordered.
package column_scorer_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int GAP_HEIGHT    = 60;
  localparam int PADDING       = 20;
  localparam int PIPE_WIDTH    = 20;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_PLAY = 2'd1,
    STATE_DEAD = 2'd2
  } state_e;

  typedef logic signed [11:0] coord_t;

  function automatic coord_t to_coord(input logic [10:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage

// File: rtl/pipe_overlap.sv
// Collision test between the bird box and one column: horizontal overlap with the
// column body while the bird is not fully inside the vertical gap.
module pipe_overlap
  import column_scorer_pkg::*;
#(
  parameter int BIRD_X    = 200,
  parameter int BIRD_SIZE = 16
) (
  input  logic [10:0] cx,
  input  logic [10:0] cy,
  input  logic [10:0] bird_y,
  output logic        col_hit
);

  localparam coord_t PIPE_SPAN = coord_t'(2 * PIPE_WIDTH - 1);
  localparam coord_t GAP       = coord_t'(GAP_HEIGHT);
  localparam coord_t BIRD_L    = coord_t'(BIRD_X);
  localparam coord_t BIRD_R    = coord_t'(BIRD_X + BIRD_SIZE - 1);
  localparam coord_t BIRD_SPAN = coord_t'(BIRD_SIZE - 1);

  coord_t col_right;
  coord_t col_left;
  coord_t gap_top;
  coord_t gap_bot;
  coord_t bird_top;
  coord_t bird_bot;
  logic   x_overlap;
  logic   y_outside;

  always_comb begin
    col_right = to_coord(cx);
    col_left  = col_right - PIPE_SPAN;
    gap_top   = to_coord(cy) - GAP;
    gap_bot   = to_coord(cy) + GAP;
    bird_top  = to_coord(bird_y);
    bird_bot  = bird_top + BIRD_SPAN;
    x_overlap = (col_right >= BIRD_L) && (col_left <= BIRD_R);
    y_outside = (bird_top < gap_top) || (bird_bot > gap_bot);
    col_hit   = x_overlap && y_outside;
  end

endmodule

// File: rtl/column_scorer.sv
// Game-state controller: detects collisions against both columns and the screen edges,
// keeps a saturating two-digit BCD score and reports finished/collide to the generator.
module column_scorer
  import column_scorer_pkg::*;
#(
  parameter int BIRD_X    = 200,
  parameter int BIRD_SIZE = 16
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] birdY,
  input  logic [10:0] Ax,
  input  logic [10:0] Ay,
  input  logic [10:0] Bx,
  input  logic [10:0] By,
  input  logic        passColumn,
  output logic        finished,
  output logic        collide,
  output logic [7:0]  score,
  output logic [1:0]  state
);

  localparam coord_t EDGE_TOP  = coord_t'(PADDING);
  localparam coord_t EDGE_BOT  = coord_t'(SCREEN_HEIGHT - 1 - PADDING);
  localparam coord_t BIRD_SPAN = coord_t'(BIRD_SIZE - 1);

  state_e     state_q, state_d;
  logic       finished_q, finished_d;
  logic       collide_q, collide_d;
  logic [7:0] score_q, score_d;
  logic       start_q;

  logic   hit_a;
  logic   hit_b;
  logic   edge_hit;
  logic   hit;
  logic   start_edge;
  coord_t bird_top;
  coord_t bird_bot;

  pipe_overlap #(.BIRD_X(BIRD_X), .BIRD_SIZE(BIRD_SIZE)) u_pipe_a (
    .cx      (Ax),
    .cy      (Ay),
    .bird_y  (birdY),
    .col_hit (hit_a)
  );

  pipe_overlap #(.BIRD_X(BIRD_X), .BIRD_SIZE(BIRD_SIZE)) u_pipe_b (
    .cx      (Bx),
    .cy      (By),
    .bird_y  (birdY),
    .col_hit (hit_b)
  );

  // Saturates at 99 rather than rolling over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    bird_top   = to_coord(birdY);
    bird_bot   = bird_top + BIRD_SPAN;
    edge_hit   = (bird_top < EDGE_TOP) || (bird_bot > EDGE_BOT);
    hit        = hit_a || hit_b || edge_hit;
    start_edge = start && !start_q;
  end

  always_comb begin
    state_d    = state_q;
    finished_d = finished_q;
    collide_d  = 1'b0;
    score_d    = score_q;
    case (state_q)
      STATE_IDLE: begin
        finished_d = 1'b1;
        if (start_edge) begin
          state_d    = STATE_PLAY;
          score_d    = 8'h00;
          finished_d = 1'b0;
        end
      end
      STATE_PLAY: begin
        finished_d = 1'b0;
        if (hit) begin
          state_d    = STATE_DEAD;
          finished_d = 1'b1;
          collide_d  = 1'b1;
        end else if (passColumn) begin
          score_d = bcd_inc(score_q);
        end
      end
      STATE_DEAD: begin
        finished_d = 1'b1;
        if (start_edge) begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d    = STATE_IDLE;
        finished_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge gameClk) begin
    if (reset) begin
      state_q    <= STATE_IDLE;
      finished_q <= 1'b1;
      collide_q  <= 1'b0;
      score_q    <= 8'h00;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= finished_d;
      collide_q  <= collide_d;
      score_q    <= score_d;
      start_q    <= start;
    end
  end

  assign finished = finished_q;
  assign collide  = collide_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule

// File: tb/tb_column_scorer.sv
// Self-checking bench for column_scorer: a vector table plus hand-built score and reset
// sequences, each cycle's expectation queued on drive and compared after the next edge.
module tb_column_scorer;

  logic        gameClk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] birdY;
  logic [10:0] Ax;
  logic [10:0] Ay;
  logic [10:0] Bx;
  logic [10:0] By;
  logic        passColumn;
  logic        finished;
  logic        collide;
  logic [7:0]  score;
  logic [1:0]  state;

  column_scorer #(.BIRD_X(200), .BIRD_SIZE(16)) dut (
    .gameClk    (gameClk),
    .reset      (reset),
    .start      (start),
    .birdY      (birdY),
    .Ax         (Ax),
    .Ay         (Ay),
    .Bx         (Bx),
    .By         (By),
    .passColumn (passColumn),
    .finished   (finished),
    .collide    (collide),
    .score      (score),
    .state      (state)
  );

  always #5 gameClk = ~gameClk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        pass;
    logic [10:0] by_bird;
    logic [10:0] ax;
    logic [10:0] ay;
    logic [10:0] bx;
    logic [10:0] by;
    logic [1:0]  e_state;
    logic        e_fin;
    logic        e_col;
    logic [7:0]  e_score;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  function automatic vec_t mk(input logic rst, input logic st, input logic pass,
                              input int bird, input int ax, input int ay,
                              input int bx, input int by,
                              input int e_state, input logic e_fin, input logic e_col,
                              input logic [7:0] e_score);
    vec_t v;
    v.rst     = rst;
    v.st      = st;
    v.pass    = pass;
    v.by_bird = 11'(bird);
    v.ax      = 11'(ax);
    v.ay      = 11'(ay);
    v.bx      = 11'(bx);
    v.by      = 11'(by);
    v.e_state = 2'(e_state);
    v.e_fin   = e_fin;
    v.e_col   = e_col;
    v.e_score = e_score;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge gameClk);
    reset      = v.rst;
    start      = v.st;
    passColumn = v.pass;
    birdY      = v.by_bird;
    Ax         = v.ax;
    Ay         = v.ay;
    Bx         = v.bx;
    By         = v.by;
    sb_q.push_back(v);
    @(posedge gameClk);
    #1;
    step_no++;
    e = sb_q.pop_front();
    chk("state",    8'(state),    8'(e.e_state));
    chk("finished", 8'(finished), 8'(e.e_fin));
    chk("collide",  8'(collide),  8'(e.e_col));
    chk("score",    score,        e.e_score);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; passColumn = 1'b0;
    birdY = 11'd232; Ax = 11'd700; Ay = 11'd240; Bx = 11'd700; By = 11'd240;

    // rst st pass birdY Ax Ay Bx By | state fin col score
    tbl.push_back(mk(1, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 210, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 232, 210, 240, 700, 240, 1, 0, 0, 8'h01));
    tbl.push_back(mk(0, 0, 1, 232, 210, 240, 700, 240, 1, 0, 0, 8'h02));
    tbl.push_back(mk(0, 0, 0, 232, 210, 240, 700, 240, 1, 0, 0, 8'h02));
    tbl.push_back(mk(0, 0, 1, 232, 210, 240, 700, 240, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 0, 0, 150, 210, 240, 700, 240, 2, 1, 1, 8'h03));
    tbl.push_back(mk(0, 0, 0, 232, 700, 240, 700, 240, 2, 1, 0, 8'h03));
    tbl.push_back(mk(0, 0, 1, 232, 700, 240, 700, 240, 2, 1, 0, 8'h03));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h03));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h03));
    tbl.push_back(mk(0, 0, 1, 232, 700, 240, 700, 240, 0, 1, 0, 8'h03));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 199, 100, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 444, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 445, 700, 240, 700, 240, 2, 1, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 200, 100, 700, 240, 2, 1, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 700, 240, 230, 100, 2, 1, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0,  20, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0,  19, 700, 240, 700, 240, 2, 1, 1, 8'h00));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // BCD carry through 09->10 and saturation at 99
    step(mk(1, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    step(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    for (int i = 1; i <= 101; i++)
      step(mk(0, 0, 1, 232, 700, 240, 700, 240, 1, 0, 0, to_bcd(i > 99 ? 99 : i)));

    // hit and passColumn together: hit wins, score frozen at 05
    step(mk(1, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    step(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    for (int i = 1; i <= 5; i++)
      step(mk(0, 0, 1, 232, 700, 240, 700, 240, 1, 0, 0, to_bcd(i)));
    step(mk(0, 0, 1, 150, 210, 240, 700, 240, 2, 1, 1, 8'h05));
    step(mk(0, 0, 1, 232, 700, 240, 700, 240, 2, 1, 0, 8'h05));

    // reset mid-game at 42 with start held through reset
    step(mk(1, 0, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    step(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    for (int i = 1; i <= 42; i++)
      step(mk(0, 0, 1, 232, 700, 240, 700, 240, 1, 0, 0, to_bcd(i)));
    step(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h42));
    step(mk(1, 1, 0, 232, 700, 240, 700, 240, 0, 1, 0, 8'h00));
    step(mk(0, 1, 0, 232, 700, 240, 700, 240, 1, 0, 0, 8'h00));
    step(mk(0, 1, 1, 232, 700, 240, 700, 240, 1, 0, 0, 8'h01));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
